// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD1602 bus arbiter: command bytes, FSM states and
// the helper that decides whether a write needs the long execution delay.
package lcd_pkg;

  localparam logic [7:0] CLEAR_DISPLAY      = 8'h01;
  localparam logic [7:0] RETURN_HOME        = 8'h02;
  localparam logic [7:0] ENTRY_MODE_INC     = 8'h06;
  localparam logic [7:0] DISPON_CURSOROFF   = 8'h0C;
  localparam logic [7:0] FUNCSET_8BIT_2LINE = 8'h38;
  localparam logic [7:0] SET_DDRAM_LINE2    = 8'hC0;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StPulse,
    StHold,
    StWait
  } lcd_state_e;

  // Clear/home style commands (0x01..0x03) take far longer to execute on the panel.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == 8'h01 || data == 8'h02 || data == 8'h03);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_bus_timer.sv
// Loadable down-counter shared by all timed bus phases; done is high while the
// count sits at zero, so a phase loaded with N-1 lasts exactly N cycles.
module lcd_bus_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] load_value,
  output logic             done
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Round-robin arbiter sharing one HD44780 8-bit write bus between two beat streams,
// with burst locking and per-transaction setup/pulse/hold/execution timing.
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES     = 4,
  parameter int unsigned PULSE_CYCLES     = 25,
  parameter int unsigned HOLD_CYCLES      = 4,
  parameter int unsigned WAIT_CYCLES      = 2500,
  parameter int unsigned WAIT_LONG_CYCLES = 80000,
  parameter int unsigned DATA_BITS        = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s0_valid,
  output logic                 s0_ready,
  input  logic                 s0_rs,
  input  logic [DATA_BITS-1:0] s0_data,
  input  logic                 s0_last,
  input  logic                 s1_valid,
  output logic                 s1_ready,
  input  logic                 s1_rs,
  input  logic [DATA_BITS-1:0] s1_data,
  input  logic                 s1_last,
  output logic                 lcd_rs,
  output logic                 lcd_rw,
  output logic                 lcd_en,
  output logic [DATA_BITS-1:0] lcd_data,
  output logic                 busy,
  output logic [1:0]           grant
);

  localparam int unsigned MaxCycles = max_u(max_u(max_u(SETUP_CYCLES, PULSE_CYCLES),
                                                  max_u(HOLD_CYCLES, WAIT_CYCLES)),
                                            WAIT_LONG_CYCLES);
  localparam int unsigned TimerW = $clog2(MaxCycles) + 1;

  localparam logic [TimerW-1:0] LdSetup = TimerW'(SETUP_CYCLES - 1);
  localparam logic [TimerW-1:0] LdPulse = TimerW'(PULSE_CYCLES - 1);
  localparam logic [TimerW-1:0] LdHold  = TimerW'(HOLD_CYCLES - 1);
  localparam logic [TimerW-1:0] LdWait  = TimerW'(WAIT_CYCLES - 1);
  localparam logic [TimerW-1:0] LdLong  = TimerW'(WAIT_LONG_CYCLES - 1);

  lcd_state_e           state_q, state_d;
  logic                 lock_q, lock_d;
  logic                 owner_q, owner_d;
  logic                 rr_q, rr_d;
  logic                 last_q, last_d;
  logic                 lcd_rs_q, lcd_rs_d;
  logic                 lcd_en_q, lcd_en_d;
  logic [DATA_BITS-1:0] lcd_data_q, lcd_data_d;
  logic                 busy_q, busy_d;
  logic [1:0]           grant_q, grant_d;

  logic              win_valid;
  logic              win_sel;
  logic              tmr_load;
  logic [TimerW-1:0] tmr_value;
  logic              tmr_done;

  lcd_bus_timer #(
    .Width(TimerW)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (tmr_load),
    .load_value(tmr_value),
    .done      (tmr_done)
  );

  // A locked burst owner is the only candidate, even while its valid is low.
  always_comb begin
    win_sel   = rr_q;
    win_valid = 1'b0;
    if (lock_q) begin
      win_sel   = owner_q;
      win_valid = owner_q ? s1_valid : s0_valid;
    end else if (s0_valid && s1_valid) begin
      win_sel   = rr_q;
      win_valid = 1'b1;
    end else if (s0_valid) begin
      win_sel   = 1'b0;
      win_valid = 1'b1;
    end else if (s1_valid) begin
      win_sel   = 1'b1;
      win_valid = 1'b1;
    end
  end

  assign s0_ready = (state_q == StIdle) && win_valid && !win_sel;
  assign s1_ready = (state_q == StIdle) && win_valid && win_sel;

  always_comb begin
    state_d    = state_q;
    lock_d     = lock_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    last_d     = last_q;
    lcd_rs_d   = lcd_rs_q;
    lcd_en_d   = lcd_en_q;
    lcd_data_d = lcd_data_q;
    busy_d     = busy_q;
    grant_d    = grant_q;
    tmr_load   = 1'b0;
    tmr_value  = '0;

    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          state_d    = StSetup;
          owner_d    = win_sel;
          lcd_rs_d   = win_sel ? s1_rs : s0_rs;
          lcd_data_d = win_sel ? s1_data : s0_data;
          last_d     = win_sel ? s1_last : s0_last;
          grant_d    = win_sel ? 2'b10 : 2'b01;
          busy_d     = 1'b1;
          if (!(win_sel ? s1_last : s0_last)) begin
            lock_d = 1'b1;
          end
          tmr_load  = 1'b1;
          tmr_value = LdSetup;
        end
      end
      StSetup: begin
        if (tmr_done) begin
          state_d   = StPulse;
          lcd_en_d  = 1'b1;
          tmr_load  = 1'b1;
          tmr_value = LdPulse;
        end
      end
      StPulse: begin
        if (tmr_done) begin
          state_d   = StHold;
          lcd_en_d  = 1'b0;
          tmr_load  = 1'b1;
          tmr_value = LdHold;
        end
      end
      StHold: begin
        if (tmr_done) begin
          state_d   = StWait;
          tmr_load  = 1'b1;
          tmr_value = is_long_cmd(lcd_rs_q, lcd_data_q[7:0]) ? LdLong : LdWait;
        end
      end
      StWait: begin
        if (tmr_done) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          // Mid-burst beats keep the lock and grant so the owner resumes uninterrupted.
          if (last_q) begin
            lock_d  = 1'b0;
            grant_d = 2'b00;
            rr_d    = ~owner_q;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      lock_q     <= 1'b0;
      owner_q    <= 1'b0;
      rr_q       <= 1'b0;
      last_q     <= 1'b0;
      lcd_rs_q   <= 1'b0;
      lcd_en_q   <= 1'b0;
      lcd_data_q <= '0;
      busy_q     <= 1'b0;
      grant_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      lock_q     <= lock_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      last_q     <= last_d;
      lcd_rs_q   <= lcd_rs_d;
      lcd_en_q   <= lcd_en_d;
      lcd_data_q <= lcd_data_d;
      busy_q     <= busy_d;
      grant_q    <= grant_d;
    end
  end

  assign lcd_rs   = lcd_rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_en   = lcd_en_q;
  assign lcd_data = lcd_data_q;
  assign busy     = busy_q;
  assign grant    = grant_q;

endmodule
